cbfp_stage: RTL and testbench

CBFP_STAGE -- requirements
Module: cbfp_stage

---
 rtl/cbfp_pkg.sv | 30 +++
 rtl/cbfp_lane_norm.sv | 56 +++++
 rtl/cbfp_stage.sv | 186 ++++++++++++++++++
 tb/tb_cbfp_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbfp_pkg.sv
// Shared types and helpers for the CBFP normalisation stage.
// Holds the FSM state enum, the shift-index width and the sign-bit counter.
package cbfp_pkg;

    typedef enum logic {
        S_SUM  = 1'b0,
        S_DIFF = 1'b1
    } state_t;

    // Width of a per-lane shift index for an in_w-bit sample.
    function automatic int idx_width(input int in_w);
        return $clog2(in_w);
    endfunction

    // Redundant sign bits of the w-bit value held in x[w-1:0] (0..w-1).
    function automatic int rsb_count(input logic [63:0] x, input int w);
        int   r;
        logic run;
        r   = 0;
        run = 1'b1;
        for (int i = 62; i >= 0; i--) begin
            if (i <= w - 2 && run) begin
                if (x[i] == x[w-1]) r++;
                else run = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cbfp_lane_norm.sv
// One lane, stages 2-3: sign-bit count of the stage-1 sample, then shift/truncate.
// Ports: clk, rstn, en (pipeline advance), din (stage-1 sample), cnt (its
// redundant-sign count), idx (shared shift aligned with stage 2), dout (result).
// Build option CBFP_ROUND_EN: round half up with saturation instead of truncation.
module cbfp_lane_norm
    import cbfp_pkg::*;
#(
    parameter  int IN_W  = 23,
    parameter  int OUT_W = 11,
    localparam int IDX_W = idx_width(IN_W)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [IN_W-1:0]  din,
    output logic [IDX_W-1:0] cnt,
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] dout
);

    logic [IN_W-1:0]  s2;
    logic [OUT_W-1:0] norm;

    assign cnt = IDX_W'(rsb_count(64'(din), IN_W));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) s2 <= '0;
        else if (en) s2 <= din;
    end

`ifdef CBFP_ROUND_EN
    localparam int RW = OUT_W + 1;
    localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};

    // Kept bits plus the first discarded bit, which is the rounding bit.
    logic [RW-1:0] rnd;
    assign rnd = RW'((s2 << idx) >> (IN_W - OUT_W - 1));

    // Only a positive maximum can overflow when rounding up.
    always_comb begin
        norm = rnd[OUT_W:1];
        if (rnd[0]) begin
            if (rnd[OUT_W:1] == MAX_POS) norm = MAX_POS;
            else norm = rnd[OUT_W:1] + 1'b1;
        end
    end
`else
    assign norm = OUT_W'((s2 << idx) >> (IN_W - OUT_W));
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) dout <= '0;
        else if (en) dout <= norm;
    end

endmodule

// File: rtl/cbfp_stage.sv
// Block-floating-point normaliser: sum beats stream through, diff beats are
// buffered and replayed after each block. 3-stage pipe: register, count, shift.
// Ports: clk, rstn, in_valid/in_ready, sum_re/im, diff_re/im (NCHAN x IN_W),
// out_valid/out_ready, out_re/im (NCHAN x OUT_W), out_idx, out_half, out_last.
// Build option CBFP_ROUND_EN (see cbfp_lane_norm).
module cbfp_stage
    import cbfp_pkg::*;
#(
    parameter  int IN_W      = 23,
    parameter  int OUT_W     = 11,
    parameter  int NCHAN     = 16,
    parameter  int BLK_BEATS = 4,
    localparam int IDX_W     = idx_width(IN_W)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [NCHAN-1:0][IN_W-1:0] sum_re,
    input  logic signed [NCHAN-1:0][IN_W-1:0] sum_im,
    input  logic signed [NCHAN-1:0][IN_W-1:0] diff_re,
    input  logic signed [NCHAN-1:0][IN_W-1:0] diff_im,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [NCHAN-1:0][OUT_W-1:0] out_re,
    output logic signed [NCHAN-1:0][OUT_W-1:0] out_im,
    output logic [NCHAN-1:0][IDX_W-1:0]       out_idx,
    output logic                              out_half,
    output logic                              out_last
);

    localparam int CNT_W  = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
    localparam int MAX_SH = IN_W - OUT_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLK_BEATS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_nxt;
    logic             stall, en, accept;
    logic             push, push_half, push_last;

    logic [NCHAN-1:0][IN_W-1:0] push_re, push_im;
    logic [NCHAN-1:0][IN_W-1:0] dbuf_re [BLK_BEATS];
    logic [NCHAN-1:0][IN_W-1:0] dbuf_im [BLK_BEATS];

    logic                       s1_v, s1_half, s1_last;
    logic [NCHAN-1:0][IN_W-1:0] s1_re, s1_im;
    logic                       s2_v, s2_half, s2_last;
    logic [NCHAN-1:0][IDX_W-1:0] s2_idx;
    logic [NCHAN-1:0][IDX_W-1:0] cnt_re, cnt_im, idx_min;

    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    // Gated by rstn so the port reads 0 while reset is held.
    assign in_ready = rstn && (state == S_SUM) && !stall;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        push      = 1'b0;
        push_half = 1'b0;
        push_last = 1'b0;
        push_re   = sum_re;
        push_im   = sum_im;
        unique case (state)
            S_SUM: begin
                if (accept) begin
                    push = 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
                        beat_nxt  = '0;
                        state_nxt = S_DIFF;
                    end else begin
                        beat_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            S_DIFF: begin
                push_half = 1'b1;
                push_last = (beat_cnt == LAST_BEAT);
                push_re   = dbuf_re[beat_cnt];
                push_im   = dbuf_im[beat_cnt];
                if (!stall) begin
                    push = 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
                        beat_nxt  = '0;
                        state_nxt = S_SUM;
                    end else begin
                        beat_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_SUM;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    // Diff lanes need no reset: every slot is rewritten before it is replayed.
    always_ff @(posedge clk) begin
        if (accept) begin
            dbuf_re[beat_cnt] <= diff_re;
            dbuf_im[beat_cnt] <= diff_im;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_v    <= 1'b0;
            s1_half <= 1'b0;
            s1_last <= 1'b0;
            s1_re   <= '0;
            s1_im   <= '0;
        end else if (en) begin
            s1_v    <= push;
            s1_half <= push && push_half;
            s1_last <= push && push_last;
            s1_re   <= push_re;
            s1_im   <= push_im;
        end
    end

    always_comb begin
        for (int g = 0; g < NCHAN; g++) begin
            idx_min[g] = (cnt_re[g] < cnt_im[g]) ? cnt_re[g] : cnt_im[g];
            if (idx_min[g] > IDX_W'(MAX_SH)) idx_min[g] = IDX_W'(MAX_SH);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_v      <= 1'b0;
            s2_half   <= 1'b0;
            s2_last   <= 1'b0;
            s2_idx    <= '0;
            out_valid <= 1'b0;
            out_half  <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
        end else if (en) begin
            s2_v      <= s1_v;
            s2_half   <= s1_half;
            s2_last   <= s1_last;
            s2_idx    <= idx_min;
            out_valid <= s2_v;
            out_half  <= s2_half;
            out_last  <= s2_last;
            out_idx   <= s2_idx;
        end
    end

    for (genvar g = 0; g < NCHAN; g++) begin : g_lane
        cbfp_lane_norm #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_re (
            .clk  (clk),
            .rstn (rstn),
            .en   (en),
            .din  (s1_re[g]),
            .cnt  (cnt_re[g]),
            .idx  (s2_idx[g]),
            .dout (out_re[g])
        );
        cbfp_lane_norm #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_im (
            .clk  (clk),
            .rstn (rstn),
            .en   (en),
            .din  (s1_im[g]),
            .cnt  (cnt_im[g]),
            .idx  (s2_idx[g]),
            .dout (out_im[g])
        );
    end

endmodule

// File: tb/tb_cbfp_stage.sv
// Scoreboard bench for cbfp_stage: directed blocks, full-rate, stall, reset.
// Expected lane values are hand-computed for IN_W=23, OUT_W=11.
module tb_cbfp_stage;

    localparam int IN_W  = 23;
    localparam int OUT_W = 11;
    localparam int NCHAN = 16;
    localparam int BLK   = 4;
    localparam int IDX_W = 5;
    localparam int HW    = 1 + 2*NCHAN*OUT_W + NCHAN*IDX_W + 2;

`ifdef CBFP_ROUND_EN
    localparam int R2 = 513;
`else
    localparam int R2 = 512;
`endif

    // Vectors 0..7 are hand-picked; 8..11 are the diff ramp 100..103.
    localparam int V_RE [12] = '{1, -4194304, 2050, 4095, 1000, -1,
                                 3, -2051, 100, 101, 102, 103};
    localparam int V_IM [12] = '{0, 0, 0, 0, -3000, 0, 5, 0, 0, 0, 0, 0};
    localparam int E_RE [12] = '{1, -1024, R2, 1023, 250, -1,
                                 3, -513, 100, 101, 102, 103};
    localparam int E_IM [12] = '{0, 0, 0, 0, -750, 0, 5, 0, 0, 0, 0, 0};
    localparam int E_IDX[12] = '{12, 0, 10, 10, 10, 12,
                                 12, 10, 12, 12, 12, 12};

    localparam int BLK_S [5][4] = '{'{0, 1, 2, 3}, '{4, 5, 6, 7},
                                   '{1, 3, 5, 7}, '{2, 4, 6, 0},
                                   '{2, 4, 6, 0}};
    localparam int BLK_D [5][4] = '{'{8, 9, 10, 11}, '{0, 1, 2, 3},
                                   '{0, 2, 4, 6}, '{9, 9, 9, 9},
                                   '{8, 9, 10, 11}};

    typedef struct {
        int re;
        int im;
        int idx;
        int half;
        int last;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    logic in_valid, in_ready;
    logic signed [NCHAN-1:0][IN_W-1:0]  sum_re, sum_im, diff_re, diff_im;
    logic out_valid, out_ready;
    logic signed [NCHAN-1:0][OUT_W-1:0] out_re, out_im;
    logic [NCHAN-1:0][IDX_W-1:0]        out_idx;
    logic out_half, out_last;

    exp_t sb[$];
    int   pop_cyc[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   blk_wait = 0;
    bit   held = 1'b0;
    logic [HW-1:0] hold_val;

    cbfp_stage #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .NCHAN     (NCHAN),
        .BLK_BEATS (BLK)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_re    (sum_re),
        .sum_im    (sum_im),
        .diff_re   (diff_re),
        .diff_im   (diff_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_half  (out_half),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_out_half"}, int'(out_half), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_out_re0"}, int'(out_re[0]), 0);
        chk({tag, "_out_im0"}, int'(out_im[0]), 0);
        chk({tag, "_out_idx0"}, int'(out_idx[0]), 0);
    endtask

    task automatic send_block(input int b, input int nb, input bit track);
        exp_t e;
        for (int i = 0; i < nb; i++) begin
            int ks;
            int kd;
            int w;
            ks = BLK_S[b][i];
            kd = BLK_D[b][i];
            for (int g = 0; g < NCHAN; g++) begin
                sum_re[g]  = IN_W'(V_RE[ks]);
                sum_im[g]  = IN_W'(V_IM[ks]);
                diff_re[g] = IN_W'(V_RE[kd]);
                diff_im[g] = IN_W'(V_IM[kd]);
            end
            in_valid = 1'b1;
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 100) begin
                w++;
                @(negedge clk);
            end
            if (i == 0) blk_wait = w;
            if (!in_ready) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: block %0d beat %0d", b, i);
            end else if (track) begin
                e = '{re: E_RE[ks], im: E_IM[ks], idx: E_IDX[ks],
                      half: 0, last: 0};
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        if (track && nb == BLK) begin
            for (int i = 0; i < BLK; i++) begin
                int kd;
                kd = BLK_D[b][i];
                e = '{re: E_RE[kd], im: E_IM[kd], idx: E_IDX[kd],
                      half: 1, last: (i == BLK - 1) ? 1 : 0};
                sb.push_back(e);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        chk("drain_left", sb.size(), 0);
        repeat (10) @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every handshake, checks hold-during-stall.
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (held) begin
                n_vec++;
                if ({out_valid, out_re, out_im, out_idx, out_half, out_last}
                    !== hold_val) begin
                    n_err++;
                    $display("FAIL stall_hold: outputs changed at cycle %0d",
                             cyc);
                end
            end
            if (out_valid && !out_ready) begin
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_in_ready: got %0b want 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                pop_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: re0=%0d at cycle %0d",
                             $signed(out_re[0]), cyc);
                end else begin
                    e = sb.pop_front();
                    if (out_re[0] !== OUT_W'(e.re) ||
                        out_re[NCHAN-1] !== OUT_W'(e.re) ||
                        out_im[0] !== OUT_W'(e.im) ||
                        out_im[NCHAN-1] !== OUT_W'(e.im) ||
                        out_idx[0] !== IDX_W'(e.idx) ||
                        out_idx[NCHAN-1] !== IDX_W'(e.idx) ||
                        out_half !== e.half[0] ||
                        out_last !== e.last[0]) begin
                        n_err++;
                        $display({"FAIL beat%0d: got re=%0d im=%0d idx=%0d ",
                                  "half=%0b last=%0b want re=%0d im=%0d ",
                                  "idx=%0d half=%0d last=%0d"},
                                 pop_cyc.size() - 1, $signed(out_re[0]),
                                 $signed(out_im[0]), out_idx[0], out_half,
                                 out_last, e.re, e.im, e.idx, e.half, e.last);
                    end
                end
            end
            held = out_valid && !out_ready;
            hold_val = {out_valid, out_re, out_im, out_idx, out_half,
                        out_last};
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sum_re    = '0;
        sum_im    = '0;
        diff_re   = '0;
        diff_im   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst0");
        @(posedge clk);
        #3 rstn = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst0", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Two blocks back to back at full rate.
        send_block(0, BLK, 1'b1);
        send_block(1, BLK, 1'b1);
        chk("in_ready_low_cycles", blk_wait, BLK);

        // Third block with a 5-cycle downstream stall.
        fork
            send_block(2, BLK, 1'b1);
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        drain();
        chk("full_rate_span",
            (pop_cyc.size() >= 8) ? pop_cyc[7] - pop_cyc[0] : -1, 7);

        // Reset after two sum beats; nothing from them may emerge.
        send_block(3, 2, 1'b0);
        in_valid = 1'b0;
        rstn     = 1'b0;
        @(negedge clk);
        check_reset("rst1");
        @(posedge clk);
        #3 rstn = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst1", int'(in_ready), 1);
        @(posedge clk);
        #1;
        send_block(4, BLK, 1'b1);
        in_valid = 1'b0;
        drain();
        chk("total_beats", pop_cyc.size(), 4 * 2 * BLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
